seq_addsub32: RTL and testbench

SEQ_ADDSUB32 -- requirements
Module: seq_addsub32

---
 rtl/seq_addsub32.sv | 192 +++++++++++++++++++
 tb/tb_seq_addsub32.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub32.sv
// Sequential 32-bit add/subtract: one 16-bit CLA is reused for the low half and then the high half.
// Define SEQ_ADDSUB32_FLAGS_EN to add the registered ovf/zero flag outputs.

module seq_addsub32_cla16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] s,
  output logic        g_blk,
  output logic        p_blk
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [3:0]  cg;

  always_comb begin
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | ((&p[4*k+1 +: 3]) & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    // Group carries come from the lookahead terms, not from rippling through bits.
    cg[0] = cin;
    cg[1] = gg[0] | (pg[0] & cin);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & cin);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = cg[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    s     = p ^ c;
    g_blk = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0]);
    p_blk = &pg;
  end

endmodule

// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// the producer holds its data until then, and ready never depends on valid.
module seq_addsub32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
`ifdef SEQ_ADDSUB32_FLAGS_EN
  output logic        ovf,
  output logic        zero,
`endif
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sub_q;
  logic [15:0] lo_q;
  logic        c16_q;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        out_valid_q;

  logic        is_hi;
  logic [15:0] op_x;
  logic [15:0] op_y;
  logic        op_cin;
  logic [15:0] cla_s;
  logic        cla_g;
  logic        cla_p;
  logic        carry_out;

`ifdef SEQ_ADDSUB32_FLAGS_EN
  logic        ovf_q;
  logic        zero_q;
  logic        c31;
  logic        ovf_next;
  logic        zero_next;
`endif

  // The adder sees the low half in every state except HI; its result is only captured in LO and HI.
  assign is_hi  = (state == HI);
  assign op_x   = is_hi ? a_q[31:16] : a_q[15:0];
  assign op_y   = is_hi ? b_q[31:16] : b_q[15:0];
  assign op_cin = is_hi ? c16_q : sub_q;

  seq_addsub32_cla16 u_cla (
    .x     (op_x),
    .y     (op_y),
    .cin   (op_cin),
    .s     (cla_s),
    .g_blk (cla_g),
    .p_blk (cla_p)
  );

  assign carry_out = cla_g | (cla_p & op_cin);

`ifdef SEQ_ADDSUB32_FLAGS_EN
  // Carry into bit 31 recovered from the sum bit and the (already inverted) operand bits.
  assign c31       = cla_s[15] ^ a_q[31] ^ b_q[31];
  assign ovf_next  = c31 ^ carry_out;
  assign zero_next = ~|{cla_s, lo_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      lo_q        <= '0;
      c16_q       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SEQ_ADDSUB32_FLAGS_EN
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {32{sub}};
            sub_q <= sub;
            state <= LO;
          end
        end
        LO: begin
          lo_q  <= cla_s;
          c16_q <= carry_out;
          state <= HI;
        end
        HI: begin
          // sum is updated as a whole here so it stays stable everywhere outside DONE.
          sum_q       <= {cla_s, lo_q};
          cout_q      <= carry_out;
          out_valid_q <= 1'b1;
`ifdef SEQ_ADDSUB32_FLAGS_EN
          ovf_q       <= ovf_next;
          zero_q      <= zero_next;
`endif
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign state_dbg = state;
`ifdef SEQ_ADDSUB32_FLAGS_EN
  assign ovf       = ovf_q;
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_seq_addsub32.sv
// Directed bench for seq_addsub32; flag checks are compiled in when SEQ_ADDSUB32_FLAGS_EN is defined.

module tb_seq_addsub32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic [1:0]  state_dbg;
`ifdef SEQ_ADDSUB32_FLAGS_EN
  logic        ovf;
  logic        zero;
`endif

  int tests_run;
  int tests_failed;

  seq_addsub32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SEQ_ADDSUB32_FLAGS_EN
    .ovf       (ovf),
    .zero      (zero),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set and lets the next edge accept it.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    a        = ta;
    b        = tb;
    sub      = ts;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = 32'h5555_AAAA;
    b        = 32'h0F0F_F0F0;
    sub      = ~ts;
  endtask

  // n = rising edges counted from the accepting edge (that edge is 1) until out_valid; bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0;
    #2;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++;
    if (sum !== 32'h0 || cout !== 1'b0) begin tests_failed++; $display("FAIL reset_sum_cout: got %h/%b want 0/0", sum, cout); end
    tests_run++;
    if (state_dbg !== S_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_carry_across();
    int n;
    out_ready = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL carry_in_ready: got %b want 1", in_ready); end
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    tests_run++;
    if (state_dbg !== S_LO || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL carry_after_accept: state %0d ov %b want %0d/0", state_dbg, out_valid, S_LO);
    end
    tick();
    tests_run++;
    if (state_dbg !== S_HI || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL carry_second_edge: state %0d ov %b want %0d/0", state_dbg, out_valid, S_HI);
    end
    n = 2;
    while (!out_valid && n < 12) begin tick(); n++; end
    tests_run++;
    if (n !== 3) begin tests_failed++; $display("FAIL carry_latency: got %0d edges want 3", n); end
    tests_run++;
    if (sum !== 32'h0001_0000 || cout !== 1'b0) begin
      tests_failed++; $display("FAIL carry_result: got %h/%b want 00010000/0", sum, cout);
    end
`ifdef SEQ_ADDSUB32_FLAGS_EN
    tests_run++;
    if (ovf !== 1'b0 || zero !== 1'b0) begin tests_failed++; $display("FAIL carry_flags: got ovf %b zero %b want 0/0", ovf, zero); end
`endif
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL carry_consume: ov %b ir %b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_borrow();
    int n;
    start_op(32'h0000_0000, 32'h0000_0001, 1'b1);
    wait_done(n);
    tests_run++;
    if (n !== 3) begin tests_failed++; $display("FAIL borrow_latency: got %0d want 3", n); end
    tests_run++;
    if (sum !== 32'hFFFF_FFFF || cout !== 1'b0) begin
      tests_failed++; $display("FAIL borrow_result: got %h/%b want ffffffff/0", sum, cout);
    end
`ifdef SEQ_ADDSUB32_FLAGS_EN
    tests_run++;
    if (ovf !== 1'b0 || zero !== 1'b0) begin tests_failed++; $display("FAIL borrow_flags: got ovf %b zero %b want 0/0", ovf, zero); end
`endif
    tick();
  endtask

  task automatic test_vectors();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vs [6];
    logic [31:0] es [6];
    logic        ec [6];
    logic        eo [6];
    int n;
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h0000_0001; vs[0] = 1'b0; es[0] = 32'h8000_0000; ec[0] = 1'b0; eo[0] = 1'b1;
    va[1] = 32'h1234_5678; vb[1] = 32'h1234_5678; vs[1] = 1'b1; es[1] = 32'h0000_0000; ec[1] = 1'b1; eo[1] = 1'b0;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; vs[2] = 1'b0; es[2] = 32'hFFFF_FFFE; ec[2] = 1'b1; eo[2] = 1'b0;
    va[3] = 32'h8000_0000; vb[3] = 32'h0000_0001; vs[3] = 1'b1; es[3] = 32'h7FFF_FFFF; ec[3] = 1'b1; eo[3] = 1'b1;
    va[4] = 32'h0000_0005; vb[4] = 32'h0000_0003; vs[4] = 1'b1; es[4] = 32'h0000_0002; ec[4] = 1'b1; eo[4] = 1'b0;
    va[5] = 32'h0000_0003; vb[5] = 32'h0000_0005; vs[5] = 1'b1; es[5] = 32'hFFFF_FFFE; ec[5] = 1'b0; eo[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], vs[i]);
      wait_done(n);
      tests_run++;
      if (n !== 3 || sum !== es[i] || cout !== ec[i]) begin
        tests_failed++;
        $display("FAIL vector_%0d: got %h/%b in %0d edges want %h/%b in 3", i, sum, cout, n, es[i], ec[i]);
      end
`ifdef SEQ_ADDSUB32_FLAGS_EN
      tests_run++;
      if (ovf !== eo[i] || zero !== (es[i] == 32'h0)) begin
        tests_failed++;
        $display("FAIL vector_%0d_flags: got ovf %b zero %b want %b/%b", i, ovf, zero, eo[i], (es[i] == 32'h0));
      end
`else
      if (eo[i] === 1'bx) $display("vector %0d has no flag reference", i);
`endif
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    start_op(32'h0001_2345, 32'h0000_FFFF, 1'b0);
    wait_done(n);
    tests_run++;
    if (n !== 3 || sum !== 32'h0002_2344 || cout !== 1'b0) begin
      tests_failed++; $display("FAIL bp_result: got %h/%b in %0d edges want 00022344/0 in 3", sum, cout, n);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 32'hDEAD_0000 + i;
      b        = 32'h0000_1111 * i;
      sub      = i[0];
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || sum !== 32'h0002_2344 || cout !== 1'b0 || in_ready !== 1'b0 || state_dbg !== S_DONE) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: ov %b sum %h cout %b ir %b st %0d want 1/00022344/0/0/%0d",
                 i, out_valid, sum, cout, in_ready, state_dbg, S_DONE);
      end
    end
    // Consume with in_valid still high: the operand on this edge must not be taken.
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_dbg !== S_IDLE) begin
      tests_failed++; $display("FAIL bp_release: ov %b ir %b st %0d want 0/1/%0d", out_valid, in_ready, state_dbg, S_IDLE);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_hi();
    int n;
    out_ready = 1'b1;
    start_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    tick();
    tests_run++;
    if (state_dbg !== S_HI) begin tests_failed++; $display("FAIL rst_reach_hi: got %0d want %0d", state_dbg, S_HI); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (state_dbg !== S_IDLE || in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h0 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async_clear: st %0d ir %b ov %b sum %h cout %b want 0/1/0/0/0", state_dbg, in_ready, out_valid, sum, cout);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || state_dbg !== S_IDLE) begin
        tests_failed++; $display("FAIL rst_no_result_%0d: ov %b st %0d want 0/%0d", i, out_valid, state_dbg, S_IDLE);
      end
    end
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(n);
    tests_run++;
    if (n !== 3 || sum !== 32'h0 || cout !== 1'b1) begin
      tests_failed++; $display("FAIL rst_recover: got %h/%b in %0d edges want 00000000/1 in 3", sum, cout, n);
    end
`ifdef SEQ_ADDSUB32_FLAGS_EN
    tests_run++;
    if (ovf !== 1'b0 || zero !== 1'b1) begin tests_failed++; $display("FAIL rst_recover_flags: got ovf %b zero %b want 0/1", ovf, zero); end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    start_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    wait_done(n);
    tests_run++;
    if (n !== 3 || sum !== 32'hFFFF_FFFF || cout !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_first: got %h/%b in %0d edges want ffffffff/0 in 3", sum, cout, n);
    end
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_after_consume: got %b want 1", in_ready); end
    start_op(32'h0000_0010, 32'h0000_0001, 1'b1);
    wait_done(n);
    tests_run++;
    if (n !== 3 || sum !== 32'h0000_000F || cout !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_second: got %h/%b in %0d edges want 0000000f/1 in 3", sum, cout, n);
    end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_carry_across();
    test_borrow();
    test_vectors();
    test_backpressure();
    test_reset_mid_hi();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
